dsm_bitstream_decimator: RTL
============================

Name: dsm_bitstream_decimator

Overview:
Receive-side counterpart of the first-order delta-sigma DAC modulator. Takes a 1-bit delta-sigma bitstream, for example from the modulator output or an external ADC modulator, and recovers multibit samples. Recovery uses a second-order CIC (sinc^2) decimation filter with ratio DECIMATION_RATIO. Produces one DATA_WIDTH-bit sample with a one-cycle valid strobe per DECIMATION_RATIO accepted input bits.

Parameters:
DATA_WIDTH, 4, output sample width in bits.
DECIMATION_RATIO, 16, input bits per output sample R; power of 2, >= 2; 2*log2(R) >= DATA_WIDTH.
ACC_WIDTH, 2*$clog2(DECIMATION_RATIO)+1, internal integrator/comb width (derived; not overridden).

Ports:
i_clk  input  1  system clock, all state updates on rising edge.
i_rst_n  input  1  reset; asynchronous, active-low.
i_bit  input  1  delta-sigma bitstream sample; 1 = +full scale, 0 = zero.
i_bit_valid  input  1  qualifies i_bit; bit consumed on a rising edge where high.
o_data  output  DATA_WIDTH  decimated sample, unsigned.
o_valid  output  1  one-cycle pulse; o_data updated in the same cycle.

Behaviour:
- Reset (i_rst_n low, asynchronous): integrators i1, i2, comb delays d1, d2, decimation counter, o_data and o_valid all cleared to 0. Takes effect immediately, mid-frame included; the partial frame is discarded.
- i_bit_valid low: all state holds; o_valid driven 0. Gaps between valid bits do not change results.
- On each accepted bit, with x = i_bit zero-extended and all arithmetic mod 2^ACC_WIDTH:
  - i1_n = i1 + x
  - i2_n = i2 + i1_n (uses the new i1)
  - The counter increments from 0 to R-1 and wraps to 0.
- Decimation event: an accepted bit with counter == R-1, i.e. the R-th bit of the frame. On the same edge:
  - c1 = i2_n - d1; d1 <= i2_n
  - c2 = c1 - d2; d2 <= c1
  - o_data <= sat(c2 >> (ACC_WIDTH-1-DATA_WIDTH))
  - o_valid <= 1
- Latency: o_valid is high in the cycle immediately after the edge that consumed the R-th bit. It is low in every other cycle.
- Scaling: c2 lies in 0..R^2. The shift maps R^2 to 2^DATA_WIDTH, which saturates to 2^DATA_WIDTH-1. No other value saturates.
- Integrator wraparound is intentional and harmless; no overflow detection is required.
- Steady state: output = round-down of (ones density x 2^DATA_WIDTH), clamped.
- The first output after reset is a filter transient: half-weight, triangular ramp-up.

Optional Feature:
DSM_DECIMATOR_SETTLE_EN
- Defined: the first decimation event after reset updates the internal comb state only. o_valid stays 0 and o_data stays 0 for that event. The second and later events behave normally. Needs one settle flag bit, which reset clears.
- Undefined: every decimation event, including the first, produces o_valid and updates o_data.

Test Plan:
1. Defaults; reset, then i_bit=1 continuously with i_bit_valid=1 -> first o_valid after bit 16 with o_data=8 (c2=136), then o_data=15 (c2=256 saturated) every 16 bits. With SETTLE_EN, the first pulse is absent and the first o_data is 15.
2. i_bit=0 continuously -> o_data=0 on every pulse, pulses spaced exactly 16 valid bits apart.
3. Alternating 1,0,1,0 from reset -> first pulse o_data=4 (c2=72), then o_data=8 (c2=128) every frame.
4. Same stream as scenario 3, but i_bit_valid randomly deasserted 0-3 cycles between bits -> identical o_data sequence; o_valid only one cycle after the 16th valid bit.
5. Assert i_rst_n low asynchronously after 9 bits of a frame -> outputs go to 0 immediately. After release, the first pulse occurs 16 bits later, with the same values as scenario 1.
6. DECIMATION_RATIO=4, DATA_WIDTH=4, all ones -> c2 sequence 10, 16, 16. o_data = 10, then 15, 15 (shift 0, saturation at 16).

Source files
------------

// File: rtl/dsm_bitstream_decimator.sv
// ---------------------------------------------------------------------------
// dsm_bitstream_decimator
//
// Recovers multibit samples from a 1-bit delta-sigma bitstream using a
// second-order CIC (sinc^2) decimator with ratio DECIMATION_RATIO (R).
// One DATA_WIDTH-bit unsigned sample is produced per R accepted input bits,
// accompanied by a one-cycle o_valid strobe.
//
// Parameters:
//   DATA_WIDTH        output sample width
//   DECIMATION_RATIO  input bits per output sample; power of 2, >= 2,
//                     2*log2(R) >= DATA_WIDTH
//   ACC_WIDTH         integrator/comb width, derived from R (leave default)
//
// Ports:
//   i_clk        system clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_bit        bitstream sample (1 = +full scale, 0 = zero)
//   i_bit_valid  qualifies i_bit; consumed on a rising edge where high
//   o_data       decimated sample, unsigned
//   o_valid      one-cycle pulse, o_data updated in the same cycle
//
// Build option:
//   DSM_DECIMATOR_SETTLE_EN  when defined, the first decimation event after
//                            reset only primes the comb state; its (half-
//                            weight transient) sample is not emitted.
// ---------------------------------------------------------------------------
module dsm_bitstream_decimator #(
    parameter int DATA_WIDTH       = 4,
    parameter int DECIMATION_RATIO = 16,
    parameter int ACC_WIDTH        = 2*$clog2(DECIMATION_RATIO)+1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_bit,
    input  logic                  i_bit_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid
);
    localparam int CNT_W = $clog2(DECIMATION_RATIO);
    // Shift that maps the full-scale comb output R^2 onto 2^DATA_WIDTH.
    localparam int SHIFT = ACC_WIDTH - 1 - DATA_WIDTH;
    // Scaled value carries one extra bit so that full scale can be detected.
    localparam int SHW   = ACC_WIDTH - SHIFT;

    logic [ACC_WIDTH-1:0]  i1_q, i2_q, d1_q, d2_q;
    logic [ACC_WIDTH-1:0]  i1_d, i2_d, c1, c2;
    logic [CNT_W-1:0]      cnt_q;
    logic [SHW-1:0]        scaled;
    logic [DATA_WIDTH-1:0] sat_data;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  dec_evt;
    logic                  emit;

    // Integrators and combs all wrap mod 2^ACC_WIDTH; the comb differences
    // remain exact because the true output never exceeds R^2 < 2^ACC_WIDTH.
    always_comb begin
        i1_d     = i1_q + {{(ACC_WIDTH-1){1'b0}}, i_bit};
        i2_d     = i2_q + i1_d;
        c1       = i2_d - d1_q;
        c2       = c1 - d2_q;
        scaled   = SHW'(c2 >> SHIFT);
        // Only c2 == R^2 sets the top bit; clamp it to all-ones.
        sat_data = scaled[DATA_WIDTH] ? {DATA_WIDTH{1'b1}} : scaled[DATA_WIDTH-1:0];
    end

    assign dec_evt = i_bit_valid && (cnt_q == CNT_W'(DECIMATION_RATIO-1));

`ifdef DSM_DECIMATOR_SETTLE_EN
    logic settled_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            settled_q <= 1'b0;
        else if (dec_evt)
            settled_q <= 1'b1;
    end

    assign emit = dec_evt && settled_q;
`else
    assign emit = dec_evt;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            i1_q    <= '0;
            i2_q    <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= emit;
            if (i_bit_valid) begin
                i1_q  <= i1_d;
                i2_q  <= i2_d;
                // R is a power of two, so the counter wraps on its own.
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (dec_evt) begin
                d1_q <= i2_d;
                d2_q <= c1;
            end
            if (emit)
                data_q <= sat_data;
        end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;

endmodule
